fwd_hazard_unit: RTL

//  Parametrised forwarding + hazard controller for an in-order pipeline of NSTAGE post-ID stages
//  (stage 0 = EX, stage NSTAGE-1 = WB). Owns a tag pipeline mirroring in-flight writers, derives
//  EX operand and ID branch-compare forward selects, and generates load-use/branch stalls.

---
 rtl/fwd_hazard_unit_pkg.sv | 21 ++
 rtl/fwd_hazard_unit_if.sv | 45 ++++
 rtl/fwd_hazard_unit_fwd_match.sv | 51 +++++
 rtl/fwd_hazard_unit.sv | 133 +++++++++++++
 4 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// rtl/fwd_hazard_unit_pkg.sv - shared encodings and helpers for the forwarding/hazard unit
// Purpose: forward-select encoding, ALU result stage, availability-check mode and the
//          per-tag result-availability helper used by every matcher.
// Ports: none (package).
package fwd_hazard_unit_pkg;

  localparam int FSEL_REGFILE = 0;  // forward select value meaning "read the register file"
  localparam int ALU_AVAIL    = 1;  // ALU results can be forwarded from stage 1 onward

  // AVAIL_AT_EX : consumer reads the operand in EX one edge later (needs avail <= k+1)
  // AVAIL_AT_ID : consumer reads the operand in ID this cycle      (needs avail <= k)
  typedef enum logic {
    AVAIL_AT_EX = 1'b0,
    AVAIL_AT_ID = 1'b1
  } avail_mode_e;

  function automatic int tag_avail(input logic is_load, input int load_stage);
    return is_load ? load_stage : ALU_AVAIL;
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// rtl/fwd_hazard_unit_if.sv - ID-side request and forward/stall response bundle
// Purpose: groups the ID instruction description, flush/hold controls and the
//          stall / forward-select / stall-count responses.
// Ports (master = pipeline side, slave = hazard unit):
//   id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_branch, id_wr_en, id_is_load, id_dst,
//   flush, hold                         : master -> slave
//   stall, fwd_a, fwd_b, fwd_cmp_a, fwd_cmp_b, stall_count : slave -> master
interface fwd_hazard_unit_if
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_W  = 5,
  parameter int FSEL_W = 2,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              id_branch;
  logic              id_wr_en;
  logic              id_is_load;
  logic [REG_W-1:0]  id_dst;
  logic              flush;
  logic              hold;
  logic              stall;
  logic [FSEL_W-1:0] fwd_a;
  logic [FSEL_W-1:0] fwd_b;
  logic [FSEL_W-1:0] fwd_cmp_a;
  logic [FSEL_W-1:0] fwd_cmp_b;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_branch, id_wr_en, id_is_load,
           id_dst, flush, hold,
    input  stall, fwd_a, fwd_b, fwd_cmp_a, fwd_cmp_b, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_branch, id_wr_en, id_is_load,
           id_dst, flush, hold,
    output stall, fwd_a, fwd_b, fwd_cmp_a, fwd_cmp_b, stall_count
  );

endinterface

// File: rtl/fwd_hazard_unit_fwd_match.sv
// rtl/fwd_hazard_unit_fwd_match.sv - youngest-writer priority encoder for one register
// Purpose: scans tags K_LO..NSTAGE-1 for the youngest valid writer of r (r0 never matches)
//          and reports whether its result is available for the requested consumer timing.
// Ports:
//   en        in  operand is actually read
//   r         in  register address looked up
//   mode      in  availability criterion (EX consumer or ID comparator)
//   t_valid, t_wr_en, t_is_load, t_dst  in  tag pipeline fields, index = stage
//   hit       out a writer was found
//   stage     out stage of the youngest writer
//   avail_ok  out that writer's result can be forwarded in time
module fwd_match
  import fwd_hazard_unit_pkg::*;
#(
  parameter int NSTAGE     = 3,
  parameter int REG_W      = 5,
  parameter int LOAD_STAGE = 2,
  parameter int K_LO       = 0,
  parameter int FSEL_W     = $clog2(NSTAGE)
) (
  input  logic                         en,
  input  logic [REG_W-1:0]             r,
  input  avail_mode_e                  mode,
  input  logic [NSTAGE-1:0]            t_valid,
  input  logic [NSTAGE-1:0]            t_wr_en,
  input  logic [NSTAGE-1:0]            t_is_load,
  input  logic [NSTAGE-1:0][REG_W-1:0] t_dst,
  output logic                         hit,
  output logic [FSEL_W-1:0]            stage,
  output logic                         avail_ok
);

  // Scan oldest to youngest so the lowest matching stage overwrites older matches.
  always_comb begin
    hit      = 1'b0;
    stage    = FSEL_W'(FSEL_REGFILE);
    avail_ok = 1'b0;
    for (int k = NSTAGE - 1; k >= K_LO; k--) begin
      if (en && (r != '0) && t_valid[k] && t_wr_en[k] && (t_dst[k] == r)) begin
        hit   = 1'b1;
        stage = FSEL_W'(k);
        if (mode == AVAIL_AT_ID) begin
          avail_ok = (tag_avail(t_is_load[k], LOAD_STAGE) <= k);
        end else begin
          avail_ok = (tag_avail(t_is_load[k], LOAD_STAGE) <= k + 1);
        end
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - forwarding and hazard controller for an NSTAGE post-ID pipeline
// Purpose: tracks in-flight writers in a tag pipeline (stage 0 = EX), derives EX operand and
//          ID comparator forward selects, raises load-use/branch stalls, counts stall cycles.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave side of fwd_hazard_unit_if (ID request, flush/hold, stall/forward outputs)
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int NSTAGE     = 3,
  parameter int REG_W      = 5,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  fwd_hazard_unit_if.slave   bus
);

  localparam int FSEL_W = $clog2(NSTAGE);

  typedef struct packed {
    logic             valid;
    logic             wr_en;
    logic             is_load;
    logic [REG_W-1:0] dst;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             use_rs;
    logic             use_rt;
  } tag_t;

  tag_t [NSTAGE-1:0] tag_q, tag_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;

  logic [NSTAGE-1:0]            t_valid, t_wr_en, t_is_load;
  logic [NSTAGE-1:0][REG_W-1:0] t_dst;

  always_comb begin
    for (int k = 0; k < NSTAGE; k++) begin
      t_valid[k]   = tag_q[k].valid;
      t_wr_en[k]   = tag_q[k].wr_en;
      t_is_load[k] = tag_q[k].is_load;
      t_dst[k]     = tag_q[k].dst;
    end
  end

  logic              ex_hit_a, ex_hit_b, ex_ok_a, ex_ok_b;
  logic [FSEL_W-1:0] ex_stage_a, ex_stage_b;
  logic              hz_hit_a, hz_hit_b, hz_ok_a, hz_ok_b;
  logic [FSEL_W-1:0] hz_stage_a, hz_stage_b;
  logic              cmp_hit_a, cmp_hit_b, cmp_ok_a, cmp_ok_b;
  logic [FSEL_W-1:0] cmp_stage_a, cmp_stage_b;
  avail_mode_e       hz_mode;
  logic              stall;

  // Non-branch consumers read in EX one edge later, branches compare in ID now.
  assign hz_mode = bus.id_branch ? AVAIL_AT_ID : AVAIL_AT_EX;

  // EX operand forwarding looks only at registered tags: the producer sits behind stage 0.
  fwd_match #(.NSTAGE(NSTAGE), .REG_W(REG_W), .LOAD_STAGE(LOAD_STAGE), .K_LO(1), .FSEL_W(FSEL_W))
    u_ex_a (.en(tag_q[0].valid & tag_q[0].use_rs), .r(tag_q[0].rs), .mode(AVAIL_AT_EX),
            .t_valid(t_valid), .t_wr_en(t_wr_en), .t_is_load(t_is_load), .t_dst(t_dst),
            .hit(ex_hit_a), .stage(ex_stage_a), .avail_ok(ex_ok_a));
  fwd_match #(.NSTAGE(NSTAGE), .REG_W(REG_W), .LOAD_STAGE(LOAD_STAGE), .K_LO(1), .FSEL_W(FSEL_W))
    u_ex_b (.en(tag_q[0].valid & tag_q[0].use_rt), .r(tag_q[0].rt), .mode(AVAIL_AT_EX),
            .t_valid(t_valid), .t_wr_en(t_wr_en), .t_is_load(t_is_load), .t_dst(t_dst),
            .hit(ex_hit_b), .stage(ex_stage_b), .avail_ok(ex_ok_b));

  // Full range for both modes: a non-branch youngest match in the last stage is always ready.
  fwd_match #(.NSTAGE(NSTAGE), .REG_W(REG_W), .LOAD_STAGE(LOAD_STAGE), .K_LO(0), .FSEL_W(FSEL_W))
    u_hz_a (.en(bus.id_use_rs), .r(bus.id_rs), .mode(hz_mode),
            .t_valid(t_valid), .t_wr_en(t_wr_en), .t_is_load(t_is_load), .t_dst(t_dst),
            .hit(hz_hit_a), .stage(hz_stage_a), .avail_ok(hz_ok_a));
  fwd_match #(.NSTAGE(NSTAGE), .REG_W(REG_W), .LOAD_STAGE(LOAD_STAGE), .K_LO(0), .FSEL_W(FSEL_W))
    u_hz_b (.en(bus.id_use_rt), .r(bus.id_rt), .mode(hz_mode),
            .t_valid(t_valid), .t_wr_en(t_wr_en), .t_is_load(t_is_load), .t_dst(t_dst),
            .hit(hz_hit_b), .stage(hz_stage_b), .avail_ok(hz_ok_b));

  fwd_match #(.NSTAGE(NSTAGE), .REG_W(REG_W), .LOAD_STAGE(LOAD_STAGE), .K_LO(0), .FSEL_W(FSEL_W))
    u_cmp_a (.en(bus.id_use_rs), .r(bus.id_rs), .mode(AVAIL_AT_ID),
             .t_valid(t_valid), .t_wr_en(t_wr_en), .t_is_load(t_is_load), .t_dst(t_dst),
             .hit(cmp_hit_a), .stage(cmp_stage_a), .avail_ok(cmp_ok_a));
  fwd_match #(.NSTAGE(NSTAGE), .REG_W(REG_W), .LOAD_STAGE(LOAD_STAGE), .K_LO(0), .FSEL_W(FSEL_W))
    u_cmp_b (.en(bus.id_use_rt), .r(bus.id_rt), .mode(AVAIL_AT_ID),
             .t_valid(t_valid), .t_wr_en(t_wr_en), .t_is_load(t_is_load), .t_dst(t_dst),
             .hit(cmp_hit_b), .stage(cmp_stage_b), .avail_ok(cmp_ok_b));

  // Flush kills the ID instruction, so it can never stall.
  assign stall = bus.id_valid & ~bus.flush & ((hz_hit_a & ~hz_ok_a) | (hz_hit_b & ~hz_ok_b));

  always_comb begin
    tag_d         = tag_q;
    stall_count_d = stall_count_q;
    if (!bus.hold) begin
      for (int k = NSTAGE - 1; k > 0; k--) begin
        tag_d[k] = tag_q[k-1];
      end
      tag_d[0] = '0;
      if (bus.id_valid && !stall && !bus.flush) begin
        tag_d[0] = '{valid: 1'b1, wr_en: bus.id_wr_en, is_load: bus.id_is_load,
                     dst: bus.id_dst, rs: bus.id_rs, rt: bus.id_rt,
                     use_rs: bus.id_use_rs, use_rt: bus.id_use_rt};
      end
      if (stall && (stall_count_q != '1)) begin
        stall_count_d = stall_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q         <= '0;
      stall_count_q <= '0;
    end else begin
      tag_q         <= tag_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.stall       = stall;
  assign bus.fwd_a       = ex_hit_a ? ex_stage_a : FSEL_W'(FSEL_REGFILE);
  assign bus.fwd_b       = ex_hit_b ? ex_stage_b : FSEL_W'(FSEL_REGFILE);
  assign bus.fwd_cmp_a   = (cmp_hit_a && cmp_ok_a) ? cmp_stage_a : FSEL_W'(FSEL_REGFILE);
  assign bus.fwd_cmp_b   = (cmp_hit_b && cmp_ok_b) ? cmp_stage_b : FSEL_W'(FSEL_REGFILE);
  assign bus.stall_count = stall_count_q;

  // Matcher outputs and tag fields that this configuration does not consume.
  logic unused_sig;
  assign unused_sig = ^{ex_ok_a, ex_ok_b, hz_stage_a, hz_stage_b, tag_q};

endmodule
